// File: rtl/debounce_pkg.sv
// Shared types and helpers for the front-panel debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, stability filter, press/release strobes
// and an optional auto-repeat FSM for held buttons.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_state,
  output logic o_down,
  output logic o_up,
  output logic o_repeat
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [CW-1:0] C_STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE     = CW'(1);
  localparam logic [RW-1:0] C_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] C_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] C_RCNT_ONE    = RW'(1);
  // Raw level that means "not pressed"; the synchroniser resets to it.
  localparam logic C_RELEASED = (ACTIVE_LOW != 0);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_state;
  logic          r_down;
  logic          r_up;
  rpt_state_t    r_rpt;
  logic [RW-1:0] r_rcnt;
  logic          r_repeat;

  logic          w_s;
  logic [CW-1:0] w_cnt_next;
  logic          w_state_next;
  logic          w_rise;
  logic          w_fall;
  rpt_state_t    w_rpt_next;
  logic [RW-1:0] w_rcnt_next;
  logic          w_repeat_next;

  assign w_s = r_sync2 ^ C_RELEASED;

  always_comb begin
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    if (w_s == r_state) begin
      w_cnt_next = '0;
    end else if (r_cnt == C_STABLE_LAST) begin
      w_state_next = w_s;
      w_cnt_next   = '0;
      w_rise       = w_s;
      w_fall       = ~w_s;
    end else begin
      w_cnt_next = r_cnt + C_CNT_ONE;
    end
  end

  // A release (including the edge at which it is decided) overrides any due repeat.
  always_comb begin
    w_rpt_next    = r_rpt;
    w_rcnt_next   = r_rcnt;
    w_repeat_next = 1'b0;
    if (w_rise) begin
      w_rpt_next  = RPT_DELAY;
      w_rcnt_next = '0;
    end else if (!r_state || w_fall) begin
      w_rpt_next  = RPT_IDLE;
      w_rcnt_next = '0;
    end else begin
      case (r_rpt)
        RPT_DELAY: begin
          if (r_rcnt == C_DELAY_LAST) begin
            w_repeat_next = 1'b1;
            w_rcnt_next   = '0;
            w_rpt_next    = RPT_REPEAT;
          end else begin
            w_rcnt_next = r_rcnt + C_RCNT_ONE;
          end
        end
        RPT_REPEAT: begin
          if (r_rcnt == C_PERIOD_LAST) begin
            w_repeat_next = 1'b1;
            w_rcnt_next   = '0;
          end else begin
            w_rcnt_next = r_rcnt + C_RCNT_ONE;
          end
        end
        default: begin
          w_rpt_next  = RPT_IDLE;
          w_rcnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= C_RELEASED;
      r_sync2  <= C_RELEASED;
      r_cnt    <= '0;
      r_state  <= 1'b0;
      r_down   <= 1'b0;
      r_up     <= 1'b0;
      r_rpt    <= RPT_IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_cnt    <= w_cnt_next;
      r_state  <= w_state_next;
      r_down   <= w_rise;
      r_up     <= w_fall;
      r_rpt    <= w_rpt_next;
      r_rcnt   <= w_rcnt_next;
      r_repeat <= w_repeat_next;
    end
  end

  assign o_state  = r_state;
  assign o_down   = r_down;
  assign o_up     = r_up;
  assign o_repeat = (REPEAT_EN != 0) ? r_repeat : 1'b0;

endmodule

// File: rtl/debouncer_array.sv
// N-channel front-panel debouncer; each channel applies the shared polarity
// setting right after its synchroniser.
module debouncer_array
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] PushButton,
  output logic [NUM_CH-1:0] PB_state,
  output logic [NUM_CH-1:0] PB_down,
  output logic [NUM_CH-1:0] PB_up,
  output logic [NUM_CH-1:0] PB_repeat
);

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raw    (PushButton[gi]),
      .o_state  (PB_state[gi]),
      .o_down   (PB_down[gi]),
      .o_up     (PB_up[gi]),
      .o_repeat (PB_repeat[gi])
    );
  end

endmodule

// File: tb/tb_debouncer_array.sv
// Bench for debouncer_array: scenario tasks plus a history-window reference model.
module tb_debouncer_array;

  localparam int NCH    = 2;
  localparam int STABLE = 8;
  localparam int RD     = 20;
  localparam int RP     = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] pb;
  logic [NCH-1:0] st;
  logic [NCH-1:0] dn;
  logic [NCH-1:0] up;
  logic [NCH-1:0] rp;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  debouncer_array #(
    .NUM_CH        (NCH),
    .STABLE_CYCLES (STABLE),
    .ACTIVE_LOW    (0),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PushButton (pb),
    .PB_state   (st),
    .PB_down    (dn),
    .PB_up      (up),
    .PB_repeat  (rp)
  );

  // Reference: a level is accepted once the synchronised input (raw sample two
  // edges back) has held one value for STABLE consecutive edges; repeats fall
  // on press+RD, then every RP edges, while the button is still accepted held.
  bit samp [NCH][$];
  bit m_state [NCH];
  bit m_down [NCH];
  bit m_up [NCH];
  bit m_rep [NCH];
  bit press_valid [NCH];
  int press_edge [NCH];
  int edge_n = 0;

  task automatic model_clear(input int c);
    samp[c].delete();
    for (int k = 0; k < 10; k++) samp[c].push_back(1'b0);
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit v;
      bit stable;
      int sz;
      if (!rst_n) begin
        m_state[c] = 0; m_down[c] = 0; m_up[c] = 0; m_rep[c] = 0;
        press_valid[c] = 0;
        model_clear(c);
      end else begin
        sz = samp[c].size();
        v = samp[c][sz-2];
        stable = (v != m_state[c]);
        for (int k = sz - 1 - STABLE; k <= sz - 2; k++)
          if (samp[c][k] != v) stable = 0;
        m_down[c] = stable && v;
        m_up[c]   = stable && !v;
        if (stable) m_state[c] = v;
        if (m_down[c]) begin
          press_edge[c]  = edge_n;
          press_valid[c] = 1;
        end
        if (!m_state[c]) press_valid[c] = 0;
        m_rep[c] = m_state[c] && press_valid[c] && (edge_n - press_edge[c] >= RD)
                   && ((edge_n - press_edge[c] - RD) % RP == 0);
        samp[c].push_back(pb[c]);
        while (samp[c].size() > 12) void'(samp[c].pop_front());
      end
    end
    edge_n++;
  endtask

  function automatic logic [7:0] exp_bundle();
    return {m_state[1], m_state[0], m_down[1], m_down[0],
            m_up[1], m_up[0], m_rep[1], m_rep[0]};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%b exp=00000000", i, {st, dn, up, rp});
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL reset_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
      if (i == 9) begin
        checks++;
        if (st !== 2'b00) begin
          failures++;
          $display("FAIL reset_early_state got=%b exp=00", st);
        end
      end
      if (i == 10) begin
        checks++;
        if (st !== 2'b11 || dn !== 2'b11) begin
          failures++;
          $display("FAIL reset_press got state=%b down=%b exp state=11 down=11", st, dn);
        end
      end
      if (i == 11) begin
        checks++;
        if (dn !== 2'b00) begin
          failures++;
          $display("FAIL reset_down_width got=%b exp=00", dn);
        end
      end
    end
    pb = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL reset_settle i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 80; i++) begin
      pb[0] = (i < 60) ? 1'((i / 3) % 2) : 1'b0;
      pb[1] = 1'b0;
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL bounce_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
      checks++;
      if ({st[0], dn[0], up[0]} !== 3'b000) begin
        failures++;
        $display("FAIL bounce_ch0 i=%0d got=%b exp=000", i, {st[0], dn[0], up[0]});
      end
    end
  endtask

  task automatic test_press_release();
    pb = 2'b10;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL press_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
      checks++;
      if (dn[1] !== (i == 10) || {st[0], dn[0], up[0], rp[0]} !== 4'b0000) begin
        failures++;
        $display("FAIL press_down1 i=%0d got down1=%b ch0=%b exp down1=%b ch0=0000",
                 i, dn[1], {st[0], dn[0], up[0], rp[0]}, (i == 10));
      end
    end
    pb = 2'b00;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL release_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
      checks++;
      if (up[1] !== (i == 10)) begin
        failures++;
        $display("FAIL release_up1 i=%0d got=%b exp=%b", i, up[1], (i == 10));
      end
    end
  endtask

  task automatic test_autorepeat();
    int nrep = 0, first = -1, down_at = -1, up_at = -1, late = 0;
    pb = 2'b01;
    for (int i = 1; i <= 130; i++) begin
      if (i == 101) pb = 2'b00;
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL repeat_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
      if (dn[0]) down_at = i;
      if (up[0]) up_at = i;
      if (rp[0]) begin
        nrep++;
        if (first < 0) first = i;
        if (up_at >= 0) late++;
      end
    end
    checks++;
    if (down_at != 10 || first - down_at != RD || up_at != 110) begin
      failures++;
      $display("FAIL repeat_timing got down=%0d first_rep=%0d up=%0d exp down=10 first_rep=30 up=110",
               down_at, first, up_at);
    end
    checks++;
    if (nrep != 16 || late != 0) begin
      failures++;
      $display("FAIL repeat_count got=%0d late=%0d exp=16 late=0", nrep, late);
    end
  endtask

  task automatic test_release_priority();
    int nrep = 0, up_at = -1, late = 0;
    pb = 2'b01;
    for (int i = 1; i <= 90; i++) begin
      if (i == 61) pb = 2'b00;
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL prio_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
      if (up[0]) up_at = i;
      if (rp[0]) begin
        nrep++;
        if (up_at >= 0) late++;
      end
    end
    checks++;
    if (up_at != 70 || nrep != 8 || late != 0) begin
      failures++;
      $display("FAIL prio_release got up=%0d reps=%0d late=%0d exp up=70 reps=8 late=0",
               up_at, nrep, late);
    end
  endtask

  task automatic test_reset_midhold();
    pb = 2'b01;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL midhold_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== 8'h00) begin
        failures++;
        $display("FAIL midhold_reset i=%0d got=%b exp=00000000", i, {st, dn, up, rp});
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL midhold_model2 i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
      checks++;
      if (dn[0] !== (i == 10) || up[0] !== 1'b0) begin
        failures++;
        $display("FAIL midhold_repress i=%0d got down=%b up=%b exp down=%b up=0",
                 i, dn[0], up[0], (i == 10));
      end
    end
    pb = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL midhold_settle i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
    end
  endtask

  task automatic test_random();
    int remain [NCH];
    for (int c = 0; c < NCH; c++) remain[c] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (remain[c] == 0) begin
          pb[c] = 1'($urandom_range(0, 1));
          remain[c] = $urandom_range(1, 40);
        end
        remain[c]--;
      end
      tick();
      checks++;
      if ({st, dn, up, rp} !== exp_bundle()) begin
        failures++;
        $display("FAIL random_model i=%0d got=%b exp=%b", i, {st, dn, up, rp}, exp_bundle());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pb = '0;
    for (int c = 0; c < NCH; c++) begin
      model_clear(c);
      press_edge[c] = 0;
    end
    @(negedge clk);
    test_reset();
    test_bounce();
    test_press_release();
    test_autorepeat();
    test_release_priority();
    test_reset_midhold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
